imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that sits directly upstream of the CPU. It accepts a word stream over a valid/ready handshake and writes the program into instruction memory at byte-addressed word slots (base, base+4, …). It then loads the program counter with the base address and releases the CPU by asserting `cpu_run`. It replaces direct preloading of instruction memory and PC with a synthesizable load path.

## Interface
Parameters:
- `MAX_WORDS`, default 1024: largest accepted program length in words.
- `CNT_W`, default 16: width of the count field and of `words_loaded`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `restart`, in, 1: synchronous request to reload; honoured only in S_RUN or S_ERR.
- `in_valid`, in, 1: stream word present.
- `in_data`, in, 32: stream word.
- `in_ready`, out, 1: loader accepts `in_data` this cycle.
- `imem_we`, out, 1: instruction memory write strobe.
- `imem_addr`, out, 32: byte address of the write (always word-aligned).
- `imem_wdata`, out, 32: instruction word.
- `pc_we`, out, 1: one-cycle strobe loading the PC.
- `pc_wdata`, out, 32: start PC, equal to the base address.
- `cpu_run`, out, 1: CPU enable; gates the CPU's PC advance.
- `words_loaded`, out, CNT_W: instruction words written so far.
- `err`, out, 1: protocol error, sticky until reset or restart.

## Operation
- A transfer occurs when `in_valid && in_ready` at a rising edge.
- Stream format: word 0 = base byte address; word 1 = count N; words 2..N+1 = instructions.
- States: S_IDLE, S_ADDR, S_COUNT, S_DATA, S_PC, S_RUN, S_ERR.
- S_IDLE → S_ADDR unconditionally on the next edge.
- S_ADDR, on transfer: latch base.
  - If `base[1:0] != 0` → S_ERR.
  - Otherwise → S_COUNT.
- S_COUNT, on transfer:
  - N > MAX_WORDS → S_ERR.
  - N == 0 → S_PC.
  - Otherwise latch N and set write pointer = base → S_DATA.
- S_DATA, on each transfer: issue one imem write at the pointer, pointer += 4, `words_loaded` += 1. After the Nth transfer → S_PC.
- S_PC: `pc_we`=1 with `pc_wdata`=base for one cycle → S_RUN.
- S_RUN: `cpu_run`=1. Held until `restart` or reset; `restart` → S_IDLE with `cpu_run` dropped.
- S_ERR: `err`=1, no writes. `restart` → S_IDLE.
- `in_ready`=1 only in S_ADDR, S_COUNT and S_DATA.
- Address arithmetic is 32-bit modulo 2^32; wrap past 0xFFFFFFFC is legal and is not an error.
- Counter arithmetic is CNT_W bits; N is taken from `in_data[CNT_W-1:0]`, and any nonzero upper bits → S_ERR.
- `in_valid` low: stall, no write, no state change. `in_data` is ignored outside transfers.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - State = S_IDLE.
  - `in_ready`, `imem_we`, `pc_we`, `cpu_run` and `err` = 0.
  - `imem_addr`, `imem_wdata`, `pc_wdata` and `words_loaded` = 0.
- `in_ready` is decoded combinationally from state. It is first 1 in the cycle after the first edge following reset release.
- The imem write is registered: a transfer at edge t drives `imem_we`/`imem_addr`/`imem_wdata` during cycle t..t+1, for exactly one cycle per word.
- `pc_we` is asserted in the cycle after the last imem write strobe, or after the count transfer when N=0. It is never asserted in the same cycle as `imem_we`.
- `cpu_run` rises on the edge that ends `pc_we`, so the minimum load time is N+4 cycles after S_IDLE.
- `restart` in any state other than S_RUN or S_ERR is ignored.
- Reset mid-load: the operation is aborted and outputs return to their reset values. Memory content already written is left as is.

## Structure
- Package `imem_loader_pkg`:
  - State enum `loader_state_t`.
  - `WORD_BYTES` = 4.
  - `ADDR_ALIGN_MASK` = 32'h3.
- Single module with no sub-module. The datapath is a base register, a pointer register and a down-counter next to the FSM.
- CPU integration: the CPU top takes `imem_we`/`imem_addr`/`imem_wdata`, `pc_we`/`pc_wdata` and `cpu_run`. The loader is driven from `clk` only; `pcClk` is not used.

## Test plan
- Stream 0x1000, 3, 0xA, 0xB, 0xC with `in_valid` held high → writes 0xA@0x1000, 0xB@0x1004, 0xC@0x1008 on three consecutive cycles; then `pc_we` with 0x1000; then `cpu_run`=1, `words_loaded`=3, `err`=0.
- Same stream with `in_valid` dropped for 2 cycles between every word → identical writes with gaps, and no writes while `in_valid`=0.
- Stream 0x2000, 0 → no `imem_we`; `pc_we` with 0x2000 one cycle after the count transfer; `cpu_run`=1.
- Base 0x1002 → `err`=1 and `in_ready`=0; a following count word is not accepted. Pulse `restart` → S_IDLE, then a valid load of 0x1000, 1, 0x20010001 succeeds.
- Count 1025 with MAX_WORDS=1024 → `err`=1 and no imem writes.
- Base 0xFFFFFFFC, N=2 → writes at 0xFFFFFFFC then 0x00000000, `err`=0.
- Assert `rst_n`=0 after 2 of 5 data words → all outputs 0 immediately. After release, a fresh full load completes with `words_loaded`=5.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_DATA,
    S_PC,
    S_RUN,
    S_ERR
  } loader_state_t;

  localparam logic [31:0] WORD_BYTES      = 32'd4;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'h3;

endpackage

// File: rtl/imem_loader.sv
// Streams base/count/words into imem, then strobes the PC and releases the CPU; imem write lands one cycle after each transfer.
// Backpressure: in_ready is high only while collecting base, count or words; stalls on in_valid low cost nothing.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             pc_we,
  output logic [31:0]      pc_wdata,
  output logic             cpu_run,
  output logic [CNT_W-1:0] words_loaded,
  output logic             err
);

  loader_state_t    r_state;
  logic [31:0]      r_base;
  logic [31:0]      r_ptr;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_words;
  logic             r_imem_we;
  logic [31:0]      r_imem_addr;
  logic [31:0]      r_imem_wdata;
  logic             r_pc_we;
  logic [31:0]      r_pc_wdata;
  logic             r_cpu_run;
  logic             r_err;

  logic             w_ready;
  logic             w_xfer;
  logic             w_base_misaligned;
  logic             w_cnt_bad;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_count;

  assign w_ready = (r_state == S_ADDR) || (r_state == S_COUNT) || (r_state == S_DATA);
  assign w_xfer  = in_valid && w_ready;
  assign w_count = in_data[CNT_W-1:0];

  assign w_base_misaligned = (in_data & ADDR_ALIGN_MASK) != 32'd0;
  // Bits above the count field must be zero; once they are, the full word equals N.
  assign w_cnt_bad  = ((in_data >> CNT_W) != 32'd0) || (in_data > 32'(MAX_WORDS));
  assign w_cnt_zero = (in_data == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_ptr        <= '0;
      r_remaining  <= '0;
      r_words      <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_pc_we      <= 1'b0;
      r_pc_wdata   <= '0;
      r_cpu_run    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      r_pc_we   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_words <= '0;
          r_state <= S_ADDR;
        end
        S_ADDR: begin
          if (w_xfer) begin
            r_base <= in_data;
            if (w_base_misaligned) begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end else begin
              r_state <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (w_xfer) begin
            if (w_cnt_bad) begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end else if (w_cnt_zero) begin
              r_state <= S_PC;
            end else begin
              r_remaining <= w_count;
              r_ptr       <= r_base;
              r_state     <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= r_ptr;
            r_imem_wdata <= in_data;
            r_ptr        <= r_ptr + WORD_BYTES;
            r_words      <= r_words + CNT_W'(1);
            r_remaining  <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_state <= S_PC;
            end
          end
        end
        S_PC: begin
          r_pc_we    <= 1'b1;
          r_pc_wdata <= r_base;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          if (restart) begin
            r_cpu_run <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cpu_run <= 1'b1;
          end
        end
        S_ERR: begin
          if (restart) begin
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = w_ready;
  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign pc_we        = r_pc_we;
  assign pc_wdata     = r_pc_wdata;
  assign cpu_run      = r_cpu_run;
  assign words_loaded = r_words;
  assign err          = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stream-level reference model checked every cycle, plus literal pins per scenario.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        restart;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        pc_we;
  logic [31:0] pc_wdata;
  logic        cpu_run;
  logic [15:0] words_loaded;
  logic        err;

  imem_loader #(.MAX_WORDS(1024), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .pc_we(pc_we), .pc_wdata(pc_wdata), .cpu_run(cpu_run),
    .words_loaded(words_loaded), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_xfer_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] sq[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [31:0] pc_data_q[$];
  int          pc_cyc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream-level model: words taken so far decide what each output must be.
  bit          m_idle, m_err, m_we, m_rdy;
  int          m_taken, m_n, m_fin, m_words;
  logic [31:0] m_base, m_addr, m_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_imem_we", 32'(imem_we), 0);
      chk("rst_pc_we", 32'(pc_we), 0);
      chk("rst_cpu_run", 32'(cpu_run), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_words", 32'(words_loaded), 0);
      m_idle = 1; m_err = 0; m_we = 0; m_taken = 0; m_n = 0; m_fin = -1; m_words = 0;
    end else begin
      if (m_fin >= 0) m_fin++;
      m_rdy = !m_idle && !m_err && (m_fin < 0);
      chk("in_ready", 32'(in_ready), 32'(m_rdy));
      chk("imem_we", 32'(imem_we), 32'(m_we));
      if (m_we && imem_we) begin
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, m_data);
      end
      if (imem_we) begin
        wr_addr_q.push_back(imem_addr);
        wr_data_q.push_back(imem_wdata);
        wr_cyc_q.push_back(cyc);
      end
      chk("pc_we", 32'(pc_we), 32'(m_fin == 2));
      if (pc_we) begin
        if (m_fin == 2) chk("pc_wdata", pc_wdata, m_base);
        pc_data_q.push_back(pc_wdata);
        pc_cyc_q.push_back(cyc);
      end
      chk("pc_we_with_imem_we", 32'(pc_we && imem_we), 0);
      chk("cpu_run", 32'(cpu_run), 32'(m_fin >= 3));
      chk("err", 32'(err), 32'(m_err));
      chk("words_loaded", 32'(words_loaded), 32'(m_words));

      m_we = 0;
      if (m_idle) begin
        m_idle = 0;
        m_words = 0;
      end else if (restart && (m_err || m_fin >= 2)) begin
        m_idle = 1; m_err = 0; m_fin = -1; m_taken = 0; m_n = 0;
      end else if (in_valid && m_rdy) begin
        if (m_taken == 0) begin
          m_base = in_data;
          if (in_data[1:0] != 2'b00) m_err = 1;
        end else if (m_taken == 1) begin
          if (in_data > 32'd1024) m_err = 1;
          else begin
            m_n = int'(in_data);
            if (m_n == 0) m_fin = 0;
          end
        end else begin
          m_we    = 1;
          m_addr  = m_base + 32'(4 * (m_taken - 2));
          m_data  = in_data;
          m_words = m_words + 1;
          if (m_taken - 1 == m_n) m_fin = 0;
        end
        m_taken++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 40) begin
        vectors++; miscompares++;
        $display("FAIL send_word timeout: word %h not accepted, in_ready=%b expected 1", w, in_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    last_xfer_cyc = cyc;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic send_stream(input int gap, input bit rs_in_gap);
    for (int i = 0; i < sq.size(); i++) begin
      send_word(sq[i]);
      if (i != sq.size() - 1) begin
        for (int g = 0; g < gap; g++) begin
          restart = rs_in_gap && (g == 0);
          tick();
        end
        restart = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!(cpu_run || err) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!(cpu_run || err)) begin
      vectors++; miscompares++;
      $display("FAIL %s timeout: cpu_run=%b err=%b, expected one of them high", name, cpu_run, err);
    end
    tick();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    pc_data_q.delete(); pc_cyc_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_in_ready"}, 32'(in_ready), 0);
    chk({name, "_imem_we"}, 32'(imem_we), 0);
    chk({name, "_imem_addr"}, imem_addr, 0);
    chk({name, "_imem_wdata"}, imem_wdata, 0);
    chk({name, "_pc_we"}, 32'(pc_we), 0);
    chk({name, "_pc_wdata"}, pc_wdata, 0);
    chk({name, "_cpu_run"}, 32'(cpu_run), 0);
    chk({name, "_words"}, 32'(words_loaded), 0);
    chk({name, "_err"}, 32'(err), 0);
  endtask

  initial begin
    rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Back-to-back three-word load
    clear_logs();
    sq = '{32'h1000, 32'd3, 32'hA, 32'hB, 32'hC};
    send_stream(0, 1'b0);
    wait_done("t1");
    chk("t1_nwr", 32'(wr_addr_q.size()), 3);
    chk("t1_a0", wr_addr_q[0], 32'h1000); chk("t1_d0", wr_data_q[0], 32'hA);
    chk("t1_a1", wr_addr_q[1], 32'h1004); chk("t1_d1", wr_data_q[1], 32'hB);
    chk("t1_a2", wr_addr_q[2], 32'h1008); chk("t1_d2", wr_data_q[2], 32'hC);
    chk("t1_gap01", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 1);
    chk("t1_gap12", 32'(wr_cyc_q[2] - wr_cyc_q[1]), 1);
    chk("t1_pc", pc_data_q[0], 32'h1000);
    chk("t1_pc_cyc", 32'(pc_cyc_q[0] - wr_cyc_q[2]), 1);
    chk("t1_run", 32'(cpu_run), 1);
    chk("t1_words", 32'(words_loaded), 3);
    chk("t1_err", 32'(err), 0);

    // Same stream with two idle cycles between words; restart during load is ignored
    do_restart();
    clear_logs();
    send_stream(2, 1'b1);
    wait_done("t2");
    chk("t2_nwr", 32'(wr_addr_q.size()), 3);
    chk("t2_a2", wr_addr_q[2], 32'h1008); chk("t2_d1", wr_data_q[1], 32'hB);
    chk("t2_gap01", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 3);
    chk("t2_words", 32'(words_loaded), 3);

    // Empty program
    do_restart();
    clear_logs();
    sq = '{32'h2000, 32'd0};
    send_stream(0, 1'b0);
    wait_done("t3");
    chk("t3_nwr", 32'(wr_addr_q.size()), 0);
    chk("t3_pc", pc_data_q[0], 32'h2000);
    chk("t3_pc_cyc", 32'(pc_cyc_q[0] - last_xfer_cyc), 1);
    chk("t3_run", 32'(cpu_run), 1);

    // Misaligned base, count word refused, then recover via restart
    do_restart();
    clear_logs();
    sq = '{32'h1002};
    send_stream(0, 1'b0);
    wait_done("t4");
    chk("t4_err", 32'(err), 1);
    in_valid = 1'b1; in_data = 32'd1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_ready_blocked", 32'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    do_restart();
    chk("t4_err_cleared", 32'(err), 0);
    sq = '{32'h1000, 32'd1, 32'h20010001};
    send_stream(0, 1'b0);
    wait_done("t4b");
    chk("t4_nwr", 32'(wr_addr_q.size()), 1);
    chk("t4_d0", wr_data_q[0], 32'h20010001);
    chk("t4_run", 32'(cpu_run), 1);
    chk("t4_words", 32'(words_loaded), 1);

    // Count one over the limit, then a count with stray upper bits
    do_restart();
    clear_logs();
    sq = '{32'h1000, 32'd1025};
    send_stream(0, 1'b0);
    wait_done("t5");
    chk("t5_err", 32'(err), 1);
    do_restart();
    sq = '{32'h1000, 32'h0001_0002};
    send_stream(0, 1'b0);
    wait_done("t5b");
    chk("t5b_err", 32'(err), 1);
    chk("t5_nwr", 32'(wr_addr_q.size()), 0);

    // Address wrap past the top of memory
    do_restart();
    clear_logs();
    sq = '{32'hFFFF_FFFC, 32'd2, 32'h11, 32'h22};
    send_stream(0, 1'b0);
    wait_done("t6");
    chk("t6_a0", wr_addr_q[0], 32'hFFFF_FFFC);
    chk("t6_a1", wr_addr_q[1], 32'h0000_0000);
    chk("t6_err", 32'(err), 0);

    // Program of exactly the maximum length
    do_restart();
    clear_logs();
    sq = '{32'h8000, 32'd1024};
    for (int i = 0; i < 1024; i++) sq.push_back(32'(i * 3 + 1));
    send_stream(0, 1'b0);
    wait_done("t7");
    chk("t7_words", 32'(words_loaded), 1024);
    chk("t7_last_addr", wr_addr_q[1023], 32'h8FFC);
    chk("t7_run", 32'(cpu_run), 1);

    // Reset after two of five data words, then a fresh complete load
    do_restart();
    clear_logs();
    send_word(32'h3000); send_word(32'd5); send_word(32'h51); send_word(32'h52);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    clear_logs();
    sq = '{32'h3000, 32'd5, 32'h51, 32'h52, 32'h53, 32'h54, 32'h55};
    send_stream(0, 1'b0);
    wait_done("t8");
    chk("t8_words", 32'(words_loaded), 5);
    chk("t8_nwr", 32'(wr_addr_q.size()), 5);
    chk("t8_a4", wr_addr_q[4], 32'h3010);
    chk("t8_run", 32'(cpu_run), 1);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
